// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the motor-control PWM stages.
//   DT_CNT_W        width of the dead-time down-counter (DEADTIME range 1..255)
//   ST_*            dead-time FSM state encodings
//   dt_state_t      enum built on those encodings, used by deadtime_gen
package pwm_pkg;

    localparam int DT_CNT_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LO_ON   = 3'd1;
    localparam logic [2:0] ST_DT_RISE = 3'd2;
    localparam logic [2:0] ST_HI_ON   = 3'd3;
    localparam logic [2:0] ST_DT_FALL = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LO_ON   = ST_LO_ON,
        S_DT_RISE = ST_DT_RISE,
        S_HI_ON   = ST_HI_ON,
        S_DT_FALL = ST_DT_FALL
    } dt_state_t;

endpackage

// File: rtl/deadtime_gen.sv
// deadtime_gen
// Turns a registered compare bit into a complementary gate pair with
// dead-time. Both gates are decoded from the state register only.
//   clk, rst   clock, synchronous active-high reset
//   raw        desired polarity (1 = high side)
//   en         enable; low forces IDLE (both gates low) on the next edge
//   hi, lo     high/low side gates
//   state_dbg  current FSM state
module deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DEADTIME = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw,
    input  logic       en,
    output logic       hi,
    output logic       lo,
    output logic [2:0] state_dbg
);

    localparam logic [DT_CNT_W-1:0] DT_LOAD = DT_CNT_W'(DEADTIME - 1);

    dt_state_t           state, state_nx;
    logic [DT_CNT_W-1:0] dt_cnt, dt_cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            dt_cnt <= '0;
        end else begin
            state  <= state_nx;
            dt_cnt <= dt_cnt_nx;
        end
    end

    // A reversal during a dead-time window returns straight to the gate
    // that was on before it, so short raw glitches never reach the
    // opposite gate.
    always_comb begin
        state_nx  = state;
        dt_cnt_nx = dt_cnt;
        if (!en) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx  = raw ? S_DT_RISE : S_DT_FALL;
                    dt_cnt_nx = DT_LOAD;
                end
                S_LO_ON: begin
                    if (raw) begin
                        state_nx  = S_DT_RISE;
                        dt_cnt_nx = DT_LOAD;
                    end
                end
                S_DT_RISE: begin
                    if (!raw)              state_nx  = S_LO_ON;
                    else if (dt_cnt == '0) state_nx  = S_HI_ON;
                    else                   dt_cnt_nx = dt_cnt - 1'b1;
                end
                S_HI_ON: begin
                    if (!raw) begin
                        state_nx  = S_DT_FALL;
                        dt_cnt_nx = DT_LOAD;
                    end
                end
                S_DT_FALL: begin
                    if (raw)               state_nx  = S_HI_ON;
                    else if (dt_cnt == '0) state_nx  = S_LO_ON;
                    else                   dt_cnt_nx = dt_cnt - 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    assign hi        = (state == S_HI_ON);
    assign lo        = (state == S_LO_ON);
    assign state_dbg = state;

endmodule

// File: rtl/center_pwm_deadtime.sv
// center_pwm_deadtime
// Center-aligned complementary PWM with dead-time, driven by an external
// triangular carrier. Duty updates go through a shadow register and only
// take effect at the carrier valley.
//   clk, rst      clock, synchronous active-high reset
//   carrier       triangular carrier 0 -> 2^WIDTH-1 -> 0
//   en            output enable (low forces both gates low)
//   duty          requested compare value
//   duty_valid    duty is presented this cycle
//   duty_ready    shadow register can accept a value
//   pwm_hi        high-side gate (registered)
//   pwm_lo        low-side gate (registered)
//   period_start  one-cycle pulse after a new duty becomes active
//   dbg_state     dead-time FSM state
module center_pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEADTIME = 4   // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] carrier,
    input  logic             en,
    input  logic [WIDTH-1:0] duty,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start,
    output logic [2:0]       dbg_state
);

    logic [WIDTH-1:0] active_duty;
    logic [WIDTH-1:0] pend_duty;
    logic             pend_full;
    logic             raw_q;
    logic             valley_load;

    // Handshake: a transfer happens at a rising edge where duty_valid and
    // duty_ready are both high. duty_ready depends only on pend_full, never
    // on duty_valid; a value offered while the shadow is full is simply
    // held off until the valley has drained it.
    assign duty_ready  = !pend_full;
    assign valley_load = (carrier == '0) && pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_duty  <= '0;
            pend_duty    <= '0;
            pend_full    <= 1'b0;
            raw_q        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            // Uses the duty active before this edge; a valley load shows up
            // in raw_q from the following edge.
            raw_q        <= (carrier < active_duty);
            period_start <= valley_load;
            // valley_load needs pend_full and a transfer needs !pend_full,
            // so the two branches never compete.
            if (valley_load) begin
                active_duty <= pend_duty;
                pend_full   <= 1'b0;
            end else if (duty_valid && duty_ready) begin
                pend_duty <= duty;
                pend_full <= 1'b1;
            end
        end
    end

    deadtime_gen #(
        .DEADTIME (DEADTIME)
    ) u_deadtime_gen (
        .clk       (clk),
        .rst       (rst),
        .raw       (raw_q),
        .en        (en),
        .hi        (pwm_hi),
        .lo        (pwm_lo),
        .state_dbg (dbg_state)
    );

endmodule
